// File: rtl/bp_sacc_vdp_driver.sv
// Job sequencer for the vector dot-product accelerator: loads operands into its scratchpad, programs CSRs, polls, reads result.
// One uncached command outstanding; message layout {data[block], payload{pad,lce_id}[16], size[3], addr[paddr], msg_type[4]}.
module bp_sacc_vdp_driver #(
  parameter int paddr_width_p = 40,
  parameter int cce_block_width_p = 128,
  parameter int lce_id_width_p = 4,
  parameter logic [paddr_width_p-1:0] csr_base_p = '0,
  parameter logic [paddr_width_p-1:0] spm_base_p = '0,
  parameter int min_wait_p = 16,
  parameter int poll_limit_p = 64,
  localparam int payload_width_lp = 16,
  localparam int hdr_width_lp = 4 + paddr_width_p + 3 + payload_width_lp,
  localparam int cce_mem_msg_width_lp = cce_block_width_p + hdr_width_lp
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [lce_id_width_p-1:0]       lce_id_i,
  input  logic [83:0]                     job_i,
  input  logic                            job_v_i,
  output logic                            job_ready_o,
  input  logic [63:0]                     elem_i,
  input  logic                            elem_v_i,
  output logic                            elem_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] io_cmd_o,
  output logic                            io_cmd_v_o,
  input  logic                            io_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0] io_resp_i,
  input  logic                            io_resp_v_i,
  output logic                            io_resp_yumi_o,
  output logic [63:0]                     result_o,
  output logic                            result_err_o,
  output logic                            result_v_o,
  input  logic                            result_yumi_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_CSR, S_WAIT_DONE, S_POLL, S_READ_RES, S_OUT
  } state_e;

  localparam logic [3:0] MSG_UC_RD  = 4'd2;
  localparam logic [3:0] MSG_UC_WR  = 4'd3;
  localparam logic [2:0] MSG_SIZE_8 = 3'b011;

  state_e                          r_state;
  logic                            r_ph_wait;
  logic                            r_cmd_v;
  logic [cce_mem_msg_width_lp-1:0] r_cmd;
  logic                            r_job_ready;
  logic                            r_result_v;
  logic                            r_err;
  logic [63:0]                     r_result;
  logic [3:0]                      r_len;
  logic [19:0]                     r_a_ptr;
  logic [19:0]                     r_b_ptr;
  logic [19:0]                     r_res_ptr;
  logic [2:0]                      r_idx;
  logic [2:0]                      r_step;
  logic [15:0]                     r_wait_cnt;
  logic [15:0]                     r_poll_cnt;

  logic [3:0]               w_job_len;
  logic [63:0]              w_resp_data;
  logic                     w_resp_fire;
  logic                     w_issue;
  logic                     w_last;
  logic [19:0]              w_ld_ptr;
  logic [paddr_width_p-1:0] w_ld_addr;
  logic [7:0]               w_csr_off;
  logic [63:0]              w_csr_val;
  logic                     w_unused;

  assign w_job_len   = job_i[3:0];
  assign w_resp_data = io_resp_i[hdr_width_lp +: 64];
  assign w_resp_fire = r_ph_wait && io_resp_v_i;
  assign w_issue     = !r_ph_wait && !r_cmd_v;
  assign w_last      = ({1'b0, r_idx} == (r_len - 4'd1));
  assign w_ld_ptr    = (r_state == S_LOAD_A) ? r_a_ptr : r_b_ptr;
  assign w_ld_addr   = spm_base_p
                     + {{(paddr_width_p-20){1'b0}}, w_ld_ptr}
                     + {{(paddr_width_p-6){1'b0}}, r_idx, 3'b000};

  assign w_unused = ^{job_i[83:64], io_resp_i[hdr_width_lp-1:0],
                      io_resp_i[cce_mem_msg_width_lp-1:hdr_width_lp+64]};

  assign job_ready_o    = r_job_ready;
  assign elem_ready_o   = ((r_state == S_LOAD_A) || (r_state == S_LOAD_B)) && w_issue;
  assign io_cmd_o       = r_cmd;
  assign io_cmd_v_o     = r_cmd_v;
  assign io_resp_yumi_o = w_resp_fire;
  assign result_o       = r_result;
  assign result_err_o   = r_err;
  assign result_v_o     = r_result_v;

  // Start (0x18) goes last so the accelerator sees a fully programmed job.
  always_comb begin
    w_csr_off = 8'h00;
    w_csr_val = 64'd0;
    case (r_step)
      3'd0: begin w_csr_off = 8'h00; w_csr_val = {44'd0, r_a_ptr};   end
      3'd1: begin w_csr_off = 8'h08; w_csr_val = {44'd0, r_b_ptr};   end
      3'd2: begin w_csr_off = 8'h10; w_csr_val = {60'd0, r_len};     end
      3'd3: begin w_csr_off = 8'h28; w_csr_val = {44'd0, r_res_ptr}; end
      3'd4: begin w_csr_off = 8'h30; w_csr_val = 64'd1;              end
      3'd5: begin w_csr_off = 8'h38; w_csr_val = 64'd0;              end
      default: begin w_csr_off = 8'h18; w_csr_val = 64'd1;           end
    endcase
  end

  function automatic logic [cce_mem_msg_width_lp-1:0] mk_cmd(
    input logic [3:0]                typ,
    input logic [paddr_width_p-1:0]  addr,
    input logic [63:0]               data,
    input logic [lce_id_width_p-1:0] lce_id
  );
    logic [cce_mem_msg_width_lp-1:0] m;
    m = '0;
    m[3:0] = typ;
    m[4 +: paddr_width_p] = addr;
    m[4 + paddr_width_p +: 3] = MSG_SIZE_8;
    m[7 + paddr_width_p +: lce_id_width_p] = lce_id;
    m[hdr_width_lp +: 64] = data;
    return m;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state     <= S_IDLE;
      r_ph_wait   <= 1'b0;
      r_cmd_v     <= 1'b0;
      r_cmd       <= '0;
      r_job_ready <= 1'b0;
      r_result_v  <= 1'b0;
      r_err       <= 1'b0;
      r_result    <= 64'd0;
      r_len       <= 4'd0;
      r_a_ptr     <= 20'd0;
      r_b_ptr     <= 20'd0;
      r_res_ptr   <= 20'd0;
      r_idx       <= 3'd0;
      r_step      <= 3'd0;
      r_wait_cnt  <= 16'd0;
      r_poll_cnt  <= 16'd0;
    end else begin
      // Command is held until the accelerator takes it, then we wait for its response.
      if (r_cmd_v && io_cmd_ready_i) begin
        r_cmd_v   <= 1'b0;
        r_ph_wait <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_job_ready <= 1'b1;
          if (r_job_ready && job_v_i) begin
            r_job_ready <= 1'b0;
            r_len       <= w_job_len;
            r_a_ptr     <= job_i[23:4];
            r_b_ptr     <= job_i[43:24];
            r_res_ptr   <= job_i[63:44];
            r_idx       <= 3'd0;
            if ((w_job_len != 4'd0) && (w_job_len <= 4'd8)) begin
              r_state <= S_LOAD_A;
            end else begin
              r_state    <= S_OUT;
              r_result   <= 64'd0;
              r_err      <= 1'b1;
              r_result_v <= 1'b1;
            end
          end
        end

        S_LOAD_A, S_LOAD_B: begin
          if (elem_ready_o && elem_v_i) begin
            r_cmd   <= mk_cmd(MSG_UC_WR, w_ld_addr, elem_i, lce_id_i);
            r_cmd_v <= 1'b1;
          end
          if (w_resp_fire) begin
            r_ph_wait <= 1'b0;
            if (w_last) begin
              r_idx   <= 3'd0;
              r_step  <= 3'd0;
              r_state <= (r_state == S_LOAD_A) ? S_LOAD_B : S_CSR;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end

        S_CSR: begin
          if (w_issue) begin
            r_cmd   <= mk_cmd(MSG_UC_WR, csr_base_p + {{(paddr_width_p-8){1'b0}}, w_csr_off},
                              w_csr_val, lce_id_i);
            r_cmd_v <= 1'b1;
          end
          if (w_resp_fire) begin
            r_ph_wait <= 1'b0;
            if (r_step == 3'd6) begin
              r_state    <= S_WAIT_DONE;
              r_wait_cnt <= 16'd0;
            end else begin
              r_step <= r_step + 3'd1;
            end
          end
        end

        S_WAIT_DONE: begin
          if (int'(r_wait_cnt) + 1 >= min_wait_p) begin
            r_state    <= S_POLL;
            r_poll_cnt <= 16'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end

        S_POLL: begin
          if (w_issue) begin
            r_cmd   <= mk_cmd(MSG_UC_RD, csr_base_p + {{(paddr_width_p-8){1'b0}}, 8'h20},
                              64'd0, lce_id_i);
            r_cmd_v <= 1'b1;
          end
          if (w_resp_fire) begin
            r_ph_wait  <= 1'b0;
            r_poll_cnt <= r_poll_cnt + 16'd1;
            if (w_resp_data != 64'd0) begin
              r_state <= S_READ_RES;
            end else if (int'(r_poll_cnt) + 1 >= poll_limit_p) begin
              r_state    <= S_OUT;
              r_result   <= 64'd0;
              r_err      <= 1'b1;
              r_result_v <= 1'b1;
            end
          end
        end

        S_READ_RES: begin
          if (w_issue) begin
            r_cmd   <= mk_cmd(MSG_UC_RD, spm_base_p + {{(paddr_width_p-20){1'b0}}, r_res_ptr},
                              64'd0, lce_id_i);
            r_cmd_v <= 1'b1;
          end
          if (w_resp_fire) begin
            r_ph_wait  <= 1'b0;
            r_result   <= w_resp_data;
            r_err      <= 1'b0;
            r_result_v <= 1'b1;
            r_state    <= S_OUT;
          end
        end

        S_OUT: begin
          if (result_yumi_i) begin
            r_result_v  <= 1'b0;
            r_job_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_sacc_vdp_driver.sv
// Bench for bp_sacc_vdp_driver: accelerator stub with scratchpad/CSRs plus an expected-command and result model.
module tb_bp_sacc_vdp_driver;
  localparam int PA = 40;
  localparam int BLK = 128;
  localparam int LW = 4;
  localparam int HDR = 4 + PA + 3 + 16;
  localparam int MSG = BLK + HDR;
  localparam logic [PA-1:0] CSR_BASE = 40'h00_0020_0000;
  localparam logic [PA-1:0] SPM_BASE = 40'h10_0000_0000;
  localparam int POLL_LIMIT = 64;
  localparam logic [3:0] UC_RD = 4'd2;
  localparam logic [3:0] UC_WR = 4'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n_i;
  logic [LW-1:0]  lce_id_i;
  logic [83:0]    job_i;
  logic           job_v_i, job_ready_o;
  logic [63:0]    elem_i;
  logic           elem_v_i, elem_ready_o;
  logic [MSG-1:0] io_cmd_o, io_resp_i;
  logic           io_cmd_v_o, io_cmd_ready_i, io_resp_v_i, io_resp_yumi_o;
  logic [63:0]    result_o;
  logic           result_err_o, result_v_o, result_yumi_i;

  bp_sacc_vdp_driver #(
    .paddr_width_p(PA), .cce_block_width_p(BLK), .lce_id_width_p(LW),
    .csr_base_p(CSR_BASE), .spm_base_p(SPM_BASE), .min_wait_p(16), .poll_limit_p(POLL_LIMIT)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .lce_id_i(lce_id_i),
    .job_i(job_i), .job_v_i(job_v_i), .job_ready_o(job_ready_o),
    .elem_i(elem_i), .elem_v_i(elem_v_i), .elem_ready_o(elem_ready_o),
    .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_i(io_cmd_ready_i),
    .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o),
    .result_o(result_o), .result_err_o(result_err_o), .result_v_o(result_v_o),
    .result_yumi_i(result_yumi_i)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MSG-1:0] mkmsg(input logic [3:0] t, input logic [PA-1:0] a,
                                           input logic [63:0] d);
    logic [MSG-1:0] m;
    m = '0;
    m[3:0] = t;
    m[4 +: PA] = a;
    m[4 + PA +: 3] = 3'b011;
    m[7 + PA +: LW] = lce_id_i;
    m[HDR +: 64] = d;
    return m;
  endfunction

  // Accelerator stub state
  logic [MSG-1:0] exp_q[$];
  logic [63:0]    spm[logic [PA-1:0]];
  logic [63:0]    csr[logic [7:0]];
  int cfg_done_polls, cfg_stall_at, cfg_stall_len, cfg_slow_delay;
  int cmd_cnt, poll_seen, stable_err, dup_err, yumi_err;
  int st, hold, dly;
  logic           seen_v;
  logic [MSG-1:0] cap, first_seen;
  logic [63:0]    rdata;

  function automatic logic [63:0] spm_rd(input logic [PA-1:0] a);
    return spm.exists(a) ? spm[a] : 64'd0;
  endfunction

  function automatic logic [63:0] csr_rd(input logic [7:0] o);
    return csr.exists(o) ? csr[o] : 64'd0;
  endfunction

  task automatic accel_start();
    logic [63:0] acc;
    acc = 64'd0;
    for (int i = 0; i < int'(csr_rd(8'h10)); i++)
      acc += spm_rd(SPM_BASE + PA'(csr_rd(8'h00)) + PA'(8 * i))
           * spm_rd(SPM_BASE + PA'(csr_rd(8'h08)) + PA'(8 * i));
    spm[SPM_BASE + PA'(csr_rd(8'h28))] = acc;
    poll_seen = 0;
  endtask

  task automatic serve(input logic [MSG-1:0] c, output logic [63:0] rd);
    logic [PA-1:0] a;
    logic [63:0] d;
    logic [MSG-1:0] e;
    a = c[4 +: PA];
    d = c[HDR +: 64];
    rd = 64'd0;
    if (exp_q.size() == 0) chk("extra_cmd", c, 0);
    else begin
      e = exp_q.pop_front();
      chk("cmd", c, e);
    end
    if (c[3:0] == UC_WR) begin
      if (a - CSR_BASE < PA'(64)) begin
        csr[8'(a - CSR_BASE)] = d;
        if (8'(a - CSR_BASE) == 8'h18 && d == 64'd1) accel_start();
      end else spm[a] = d;
    end else if (a == CSR_BASE + PA'(32)) begin
      rd = (cfg_done_polls >= 0 && poll_seen >= cfg_done_polls) ? 64'd1 : 64'd0;
      poll_seen++;
    end else rd = spm_rd(a);
  endtask

  initial begin
    io_cmd_ready_i = 1'b0; io_resp_v_i = 1'b0; io_resp_i = '0;
    st = 0; hold = 0; dly = 0; seen_v = 1'b0; cap = '0; first_seen = '0; rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset_n_i) begin
        if (io_resp_v_i) chk("rst_no_yumi", io_resp_yumi_o, 0);
        io_cmd_ready_i = 1'b0; io_resp_v_i = 1'b0; st = 0; hold = 0; seen_v = 1'b0;
      end else begin
        case (st)
          0: if (io_cmd_v_o) begin
            if (!seen_v) begin
              seen_v = 1'b1;
              first_seen = io_cmd_o;
              hold = (cmd_cnt == cfg_stall_at) ? cfg_stall_len : int'($urandom_range(0, 1));
            end else if (io_cmd_o !== first_seen) stable_err++;
            if (hold == 0) begin
              io_cmd_ready_i = 1'b1; cap = io_cmd_o; st = 1;
            end else hold--;
          end
          1: begin
            io_cmd_ready_i = 1'b0; seen_v = 1'b0;
            if (io_cmd_v_o) dup_err++;
            serve(cap, rdata);
            dly = (cmd_cnt == cfg_stall_at) ? cfg_slow_delay : int'($urandom_range(0, 2));
            cmd_cnt++;
            st = 2;
          end
          2: if (dly > 0) dly--;
             else begin
               io_resp_i = '0;
               io_resp_i[HDR-1:0] = cap[HDR-1:0];
               io_resp_i[HDR +: 64] = rdata;
               io_resp_v_i = 1'b1;
               #1;
               if (!io_resp_yumi_o) yumi_err++;
               st = 3;
             end
          default: begin io_resp_v_i = 1'b0; st = 0; end
        endcase
      end
    end
  end

  logic [63:0] va[16], vb[16];

  function automatic logic [63:0] stream(input int k, input int len);
    return (k < len) ? va[k] : vb[k - len];
  endfunction

  // One job: model expected commands/result, drive it, check. abort_after>=0 resets mid-stream.
  task automatic run_job(input int len, input logic [19:0] a, input logic [19:0] b,
                         input logic [19:0] r, input int done_polls, input int stall_at,
                         input int stall_len, input int slow_delay, input int abort_after);
    bit ok_len, done;
    int npolls, nfeed, k, t, surplus, busy_rdy;
    logic [63:0] exp_res;
    logic take;
    ok_len = (len >= 1 && len <= 8);
    done = (done_polls >= 0 && done_polls < POLL_LIMIT);
    cfg_done_polls = done_polls; cfg_stall_at = stall_at;
    cfg_stall_len = stall_len; cfg_slow_delay = slow_delay;
    cmd_cnt = 0; stable_err = 0; dup_err = 0; yumi_err = 0;
    exp_q.delete();
    exp_res = 64'd0;
    if (ok_len) begin
      for (int i = 0; i < len; i++) exp_q.push_back(mkmsg(UC_WR, SPM_BASE + PA'(a) + PA'(8 * i), va[i]));
      for (int i = 0; i < len; i++) exp_q.push_back(mkmsg(UC_WR, SPM_BASE + PA'(b) + PA'(8 * i), vb[i]));
      exp_q.push_back(mkmsg(UC_WR, CSR_BASE + PA'(0),  64'(a)));
      exp_q.push_back(mkmsg(UC_WR, CSR_BASE + PA'(8),  64'(b)));
      exp_q.push_back(mkmsg(UC_WR, CSR_BASE + PA'(16), 64'(len)));
      exp_q.push_back(mkmsg(UC_WR, CSR_BASE + PA'(40), 64'(r)));
      exp_q.push_back(mkmsg(UC_WR, CSR_BASE + PA'(48), 64'd1));
      exp_q.push_back(mkmsg(UC_WR, CSR_BASE + PA'(56), 64'd0));
      exp_q.push_back(mkmsg(UC_WR, CSR_BASE + PA'(24), 64'd1));
      npolls = done ? done_polls + 1 : POLL_LIMIT;
      for (int i = 0; i < npolls; i++) exp_q.push_back(mkmsg(UC_RD, CSR_BASE + PA'(32), 64'd0));
      if (done) begin
        exp_q.push_back(mkmsg(UC_RD, SPM_BASE + PA'(r), 64'd0));
        for (int i = 0; i < len; i++) exp_res += va[i] * vb[i];
      end
    end
    job_i = {20'd0, r, b, a, 4'(len)};
    job_v_i = 1'b1;
    t = 0;
    while (!job_ready_o && t < 50) begin @(negedge clk); t++; end
    chk("job_accept", job_ready_o, 1);
    @(negedge clk);
    nfeed = !ok_len ? 0 : (abort_after >= 0 ? abort_after : 2 * len);
    k = 0; t = 0;
    while (k < nfeed && t < 5000) begin
      elem_i = stream(k, len);
      elem_v_i = ($urandom_range(0, 3) != 0);
      take = elem_v_i && elem_ready_o;
      @(negedge clk); t++;
      if (take) k++;
    end
    if (abort_after >= 0) begin
      reset_n_i = 1'b0; elem_v_i = 1'b0; job_v_i = 1'b0;
      @(negedge clk);
      chk("rst_job_ready", job_ready_o, 0);
      chk("rst_outs", {elem_ready_o, io_cmd_v_o, io_resp_yumi_o, result_v_o, result_err_o}, 0);
      chk("rst_result", result_o, 0);
      @(negedge clk);
      exp_q.delete();
      reset_n_i = 1'b1;
      @(negedge clk);
      chk("rst_release_ready", job_ready_o, 1);
      return;
    end
    elem_v_i = 1'b1; elem_i = 64'hDEAD_BEEF_0BAD_F00D;
    t = 0; surplus = 0; busy_rdy = 0;
    while (!result_v_o && t < 3000) begin
      if (elem_ready_o) surplus++;
      if (job_ready_o) busy_rdy++;
      @(negedge clk); t++;
    end
    chk("result_timeout", result_v_o, 1);
    if (!ok_len) chk("err_latency", (t <= 1), 1);
    chk("result", result_o, exp_res);
    chk("result_err", result_err_o, !(ok_len && done));
    chk("surplus_elem", surplus, 0);
    chk("busy_ready", busy_rdy, 0);
    elem_v_i = 1'b0; job_v_i = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    chk("result_hold", result_v_o, 1);
    result_yumi_i = 1'b1;
    @(negedge clk);
    result_yumi_i = 1'b0;
    chk("result_drop", result_v_o, 0);
    chk("cmds_left", exp_q.size(), 0);
    chk("cmd_stable", stable_err, 0);
    chk("cmd_dup", dup_err, 0);
    chk("resp_yumi", yumi_err, 0);
  endtask

  initial begin
    reset_n_i = 1'b0; lce_id_i = 4'h5; job_i = '0; job_v_i = 1'b0;
    elem_i = '0; elem_v_i = 1'b0; result_yumi_i = 1'b0;
    cfg_done_polls = 0; cfg_stall_at = -1; cfg_stall_len = 0; cfg_slow_delay = 0;
    cmd_cnt = 0; poll_seen = 0; stable_err = 0; dup_err = 0; yumi_err = 0;
    repeat (3) @(negedge clk);
    chk("reset_job_ready", job_ready_o, 0);
    chk("reset_outs", {elem_ready_o, io_cmd_v_o, io_resp_yumi_o, result_v_o, result_err_o}, 0);
    chk("reset_result", result_o, 0);
    reset_n_i = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", job_ready_o, 1);

    va[0] = 1; va[1] = 2; va[2] = 3; vb[0] = 4; vb[1] = 5; vb[2] = 6;
    run_job(3, 20'h00, 20'h40, 20'h80, 2, -1, 0, 0, -1);

    for (int i = 0; i < 8; i++) begin va[i] = '1; vb[i] = '1; end
    run_job(8, 20'h100, 20'h200, 20'h300, 0, -1, 0, 0, -1);

    run_job(0, 20'h0, 20'h40, 20'h80, 0, -1, 0, 0, -1);
    run_job(9, 20'h0, 20'h40, 20'h80, 0, -1, 0, 0, -1);

    for (int i = 0; i < 3; i++) begin va[i] = 64'(i + 7); vb[i] = 64'(3 * i + 1); end
    run_job(3, 20'h10, 20'h50, 20'h90, 1, 2, 5, 7, -1);

    run_job(2, 20'h0, 20'h40, 20'h80, -1, -1, 0, 0, -1);

    run_job(3, 20'h0, 20'h40, 20'h80, 0, -1, 0, 0, 4);
    va[0] = 64'd11; va[1] = 64'd12; vb[0] = 64'd13; vb[1] = 64'd14;
    run_job(2, 20'h8, 20'h48, 20'h88, 1, -1, 0, 0, -1);

    for (int j = 0; j < 4; j++) begin
      int len;
      len = int'($urandom_range(1, 8));
      for (int i = 0; i < 8; i++) begin va[i] = {$urandom, $urandom}; vb[i] = {$urandom, $urandom}; end
      run_job(len, 20'($urandom_range(0, 255) * 8), 20'h1000 + 20'($urandom_range(0, 255) * 8),
              20'h3000 + 20'($urandom_range(0, 255) * 8), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 10)), int'($urandom_range(1, 4)), int'($urandom_range(0, 6)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
